huffman_canon_gen: RTL

HUFFMAN_CANON_GEN -- requirements
Module: huffman_canon_gen

---
 rtl/huffman_pkg.sv | 24 ++
 rtl/huffman_next_code.sv | 82 ++++++++
 rtl/huffman_canon_gen.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/huffman_pkg.sv
// Shared definitions for the canonical Huffman code generator: default
// geometry, FSM state encoding and the Code_out field layout.
package huffman_pkg;

    // Default table geometry.
    localparam int HC_NSYM_DEF   = 10;
    localparam int HC_MAXLEN_DEF = 9;
    localparam int HC_LW_DEF     = 4;
    localparam int HC_SW_DEF     = 4;

    // Code_out = {length, code}: the code sits right-aligned in the low
    // MAXLEN bits and the length field starts at bit MAXLEN.
    localparam int HC_CODE_LSB = 0;
    localparam int HC_LEN_LSB_DEF = HC_MAXLEN_DEF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_NEXT = 3'd2,
        ST_EMIT = 3'd3,
        ST_DONE = 3'd4
    } hc_state_t;

endpackage

// File: rtl/huffman_next_code.sv
// Length histogram (bl_count) and next_code register file.  Runs the
// canonical recurrence one length per step and flags oversubscription of a
// length while that length's first code is being computed.
module huffman_next_code #(
    parameter int MAXLEN = 9,
    parameter int LW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_cnt_en,
    input  logic [LW-1:0]     i_cnt_len,
    input  logic              i_step_en,
    input  logic [LW-1:0]     i_step_b,
    input  logic              i_use_en,
    input  logic [LW-1:0]     i_use_len,
    output logic [MAXLEN-1:0] o_code,
    output logic              o_oversub
);

    localparam int CW = MAXLEN + 1;
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [LW-1:0] L_ONE   = LW'(1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAXLEN);

    logic [CW-1:0] r_bl_count  [0:MAXLEN];
    logic [CW-1:0] r_next_code [0:MAXLEN];
    logic [CW-1:0] r_code;

    logic [CW-1:0] w_prev_cnt;
    logic [CW-1:0] w_sum;
    logic [CW-1:0] w_code_new;
    logic [CW:0]   w_check;
    logic [CW:0]   w_limit;

    // Recurrence for length b: code = (code + bl_count[b-1]) << 1, with the
    // unused-symbol bucket bl_count[0] excluded; plus the 2^b capacity test.
    always_comb begin
        w_prev_cnt = '0;
        if (i_step_b > L_ONE) begin
            w_prev_cnt = r_bl_count[i_step_b - L_ONE];
        end
        w_sum      = r_code + w_prev_cnt;
        w_code_new = w_sum << 1;
        w_check    = {1'b0, w_code_new} + {1'b0, r_bl_count[i_step_b]};
        w_limit    = (CW+1)'(1) << i_step_b;
        o_oversub  = i_step_en && (w_check > w_limit);
        o_code     = '0;
        if (i_use_len <= LEN_MAX) begin
            o_code = r_next_code[i_use_len][MAXLEN-1:0];
        end
    end

    // Histogram counting, recurrence steps and per-length code increments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= MAXLEN; i++) begin
                r_bl_count[i]  <= '0;
                r_next_code[i] <= '0;
            end
            r_code <= '0;
        end else if (i_clear) begin
            for (int i = 0; i <= MAXLEN; i++) begin
                r_bl_count[i]  <= '0;
                r_next_code[i] <= '0;
            end
            r_code <= '0;
        end else begin
            if (i_cnt_en) begin
                r_bl_count[i_cnt_len] <= r_bl_count[i_cnt_len] + C_ONE;
            end
            if (i_step_en) begin
                r_next_code[i_step_b] <= w_code_new;
                r_code                <= w_code_new;
            end
            if (i_use_en) begin
                r_next_code[i_use_len] <= r_next_code[i_use_len] + C_ONE;
            end
        end
    end

endmodule

// File: rtl/huffman_canon_gen.sv
// Canonical Huffman code generator: loads NSYM code lengths, builds the
// next_code table, then emits {length, code} for every symbol in order.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high.  The producer holds valid and its data stable until
// that edge; ready may change freely and never waits on valid.
module huffman_canon_gen
    import huffman_pkg::*;
#(
    parameter int NSYM   = HC_NSYM_DEF,
    parameter int MAXLEN = HC_MAXLEN_DEF,
    parameter int LW     = HC_LW_DEF,
    parameter int SW     = HC_SW_DEF
) (
    input  logic                 Clk_in,
    input  logic                 Rst,
    input  logic                 Start_code,
    input  logic                 Len_valid,
    input  logic [LW-1:0]        Len_in,
    output logic                 Len_ready,
    output logic                 Code_valid,
    input  logic                 Code_ready,
    output logic [SW-1:0]        Code_sym,
    output logic [LW+MAXLEN-1:0] Code_out,
    output logic                 Fin,
    output logic                 Err,
    output logic [2:0]           o_dbg_state
);

    localparam logic [SW:0]   SYM_LAST = (SW+1)'(NSYM - 1);
    localparam logic [SW:0]   SYM_END  = (SW+1)'(NSYM);
    localparam logic [SW:0]   SYM_ONE  = (SW+1)'(1);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAXLEN);
    localparam logic [LW-1:0] LEN_ONE  = LW'(1);

    hc_state_t             r_state;
    hc_state_t             w_state_nxt;
    logic                  r_start_d;
    logic [SW:0]           r_sym_idx;
    logic [LW-1:0]         r_bit_idx;
    logic [LW-1:0]         r_len_mem [0:NSYM-1];
    logic                  r_err;
    logic                  r_code_valid;
    logic [SW-1:0]         r_code_sym;
    logic [LW+MAXLEN-1:0]  r_code_out;

    logic                  w_start_rise;
    logic                  w_clear;
    logic                  w_len_hs;
    logic                  w_last_len;
    logic                  w_next_last;
    logic                  w_code_hs;
    logic                  w_emit_load;
    logic                  w_emit_last;
    logic [LW-1:0]         w_emit_len;
    logic [MAXLEN-1:0]     w_nc;
    logic                  w_oversub;

    // Event decode shared by the FSM and the datapath.
    always_comb begin
        w_start_rise = Start_code && !r_start_d;
        w_clear      = (r_state == ST_IDLE) && w_start_rise;
        w_len_hs     = (r_state == ST_LOAD) && Len_valid;
        w_last_len   = w_len_hs && (r_sym_idx == SYM_LAST);
        w_next_last  = (r_state == ST_NEXT) && (r_bit_idx == LEN_MAX);
        w_code_hs    = r_code_valid && Code_ready;
        w_emit_load  = (r_state == ST_EMIT) && (r_sym_idx < SYM_END) &&
                       (!r_code_valid || Code_ready);
        w_emit_last  = (r_state == ST_EMIT) && w_code_hs && (r_sym_idx == SYM_END);
        w_emit_len   = '0;
        if (r_sym_idx < SYM_END) begin
            w_emit_len = r_len_mem[r_sym_idx[SW-1:0]];
        end
    end

    // State register.
    always_ff @(posedge Clk_in or posedge Rst) begin
        if (Rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; an invalid table skips EMIT entirely.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start_rise) w_state_nxt = ST_LOAD;
            ST_LOAD: if (w_last_len)   w_state_nxt = ST_NEXT;
            ST_NEXT: if (w_next_last)  w_state_nxt = (r_err || w_oversub) ? ST_DONE : ST_EMIT;
            ST_EMIT: if (w_emit_last)  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        Len_ready   = (r_state == ST_LOAD);
        Fin         = (r_state == ST_DONE);
        o_dbg_state = r_state;
    end

    // Previous Start_code level; a start needs a fresh rising edge.
    always_ff @(posedge Clk_in or posedge Rst) begin
        if (Rst) r_start_d <= 1'b0;
        else     r_start_d <= Start_code;
    end

    // Symbol index (LOAD and EMIT) and bit-length index (NEXT).
    always_ff @(posedge Clk_in or posedge Rst) begin
        if (Rst) begin
            r_sym_idx <= '0;
            r_bit_idx <= '0;
        end else begin
            if (w_clear)          r_sym_idx <= '0;
            else if (w_len_hs)    r_sym_idx <= w_last_len ? '0 : r_sym_idx + SYM_ONE;
            else if (w_emit_load) r_sym_idx <= r_sym_idx + SYM_ONE;
            if (w_last_len)                              r_bit_idx <= LEN_ONE;
            else if ((r_state == ST_NEXT) && !w_next_last) r_bit_idx <= r_bit_idx + LEN_ONE;
        end
    end

    // Sticky error: out-of-range length or an oversubscribed length.
    always_ff @(posedge Clk_in or posedge Rst) begin
        if (Rst) begin
            r_err <= 1'b0;
        end else if (w_clear) begin
            r_err <= 1'b0;
        end else begin
            if (w_len_hs && (Len_in > LEN_MAX))     r_err <= 1'b1;
            if ((r_state == ST_NEXT) && w_oversub) r_err <= 1'b1;
        end
    end

    // Per-symbol length store, filled in symbol order.
    always_ff @(posedge Clk_in or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < NSYM; i++) r_len_mem[i] <= '0;
        end else if (w_clear) begin
            for (int i = 0; i < NSYM; i++) r_len_mem[i] <= '0;
        end else if (w_len_hs) begin
            r_len_mem[r_sym_idx[SW-1:0]] <= Len_in;
        end
    end

    // Registered code output; refilled on the edge the current word leaves.
    always_ff @(posedge Clk_in or posedge Rst) begin
        if (Rst) begin
            r_code_valid <= 1'b0;
            r_code_sym   <= '0;
            r_code_out   <= '0;
        end else if (w_emit_load) begin
            r_code_valid <= 1'b1;
            r_code_sym   <= r_sym_idx[SW-1:0];
            r_code_out   <= (w_emit_len == '0) ? '0 : {w_emit_len, w_nc};
        end else if (w_code_hs) begin
            r_code_valid <= 1'b0;
        end
    end

    assign Code_valid = r_code_valid;
    assign Code_sym   = r_code_sym;
    assign Code_out   = r_code_out;
    assign Err        = r_err;

    huffman_next_code #(
        .MAXLEN (MAXLEN),
        .LW     (LW)
    ) u_next_code (
        .clk       (Clk_in),
        .rst       (Rst),
        .i_clear   (w_clear),
        .i_cnt_en  (w_len_hs && (Len_in <= LEN_MAX)),
        .i_cnt_len (Len_in),
        .i_step_en (r_state == ST_NEXT),
        .i_step_b  (r_bit_idx),
        .i_use_en  (w_emit_load && (w_emit_len != '0)),
        .i_use_len (w_emit_len),
        .o_code    (w_nc),
        .o_oversub (w_oversub)
    );

endmodule
